// File: rtl/native_feeder.sv
// Packs narrow operand beats into flat vectors, fires the dot-product engine and returns its result.
// Start is issued the cycle after the last beat; the result is held in HOLD until m_ready, and s_ready stays low meanwhile.
module native_feeder #(
  parameter int N            = 128,
  parameter int WEIGHT_WIDTH = 4,
  parameter int ACT_WIDTH    = 4,
  parameter int BEAT_LANES   = 16,
  parameter int TIMEOUT      = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [BEAT_LANES*WEIGHT_WIDTH-1:0] s_weights,
  input  logic [BEAT_LANES*ACT_WIDTH-1:0]    s_acts,
  output logic                         eng_start,
  output logic [N*WEIGHT_WIDTH-1:0]    eng_weights_flat,
  output logic [N*ACT_WIDTH-1:0]       eng_acts_flat,
  input  logic                         eng_done,
  input  logic [15:0]                  eng_result,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [15:0]                  m_result,
  output logic                         m_timeout,
  output logic [15:0]                  op_count,
  output logic                         busy
);

  localparam int NBEATS = N / BEAT_LANES;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int CW     = $clog2(TIMEOUT + 1);
  localparam int BWW    = BEAT_LANES * WEIGHT_WIDTH;
  localparam int BAW    = BEAT_LANES * ACT_WIDTH;

  typedef enum logic [1:0] {FILL, FIRE, WAIT, HOLD} state_t;

  state_t                      state_q, state_d;
  logic [BW-1:0]               beat_q, beat_d;
  logic [CW-1:0]               wait_q, wait_d;
  logic [N*WEIGHT_WIDTH-1:0]   w_flat_q, w_flat_d;
  logic [N*ACT_WIDTH-1:0]      a_flat_q, a_flat_d;
  logic                        eng_start_q, eng_start_d;
  logic                        m_valid_q, m_valid_d;
  logic [15:0]                 m_result_q, m_result_d;
  logic                        m_timeout_q, m_timeout_d;
  logic [15:0]                 op_count_q, op_count_d;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    wait_d      = wait_q;
    w_flat_d    = w_flat_q;
    a_flat_d    = a_flat_q;
    eng_start_d = 1'b0;
    m_valid_d   = m_valid_q;
    m_result_d  = m_result_q;
    m_timeout_d = m_timeout_q;
    op_count_d  = op_count_q;
    case (state_q)
      FILL: begin
        if (s_valid) begin
          for (int b = 0; b < NBEATS; b++) begin
            if (beat_q == b[BW-1:0]) begin
              w_flat_d[b*BWW +: BWW] = s_weights;
              a_flat_d[b*BAW +: BAW] = s_acts;
            end
          end
          if (beat_q == BW'(NBEATS - 1)) begin
            beat_d      = '0;
            state_d     = FIRE;
            eng_start_d = 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      FIRE: begin
        state_d = WAIT;
        wait_d  = '0;
      end
      WAIT: begin
        wait_d = wait_q + 1'b1;
        // A done arriving on the limit cycle still counts as a real result.
        if (eng_done) begin
          m_result_d  = eng_result;
          m_timeout_d = 1'b0;
          m_valid_d   = 1'b1;
          state_d     = HOLD;
        end else if (wait_q == CW'(TIMEOUT - 1)) begin
          m_result_d  = '0;
          m_timeout_d = 1'b1;
          m_valid_d   = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (m_ready) begin
          if (!m_timeout_q) op_count_d = op_count_q + 1'b1;
          m_valid_d   = 1'b0;
          m_timeout_d = 1'b0;
          state_d     = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= FILL;
      beat_q      <= '0;
      wait_q      <= '0;
      w_flat_q    <= '0;
      a_flat_q    <= '0;
      eng_start_q <= 1'b0;
      m_valid_q   <= 1'b0;
      m_result_q  <= '0;
      m_timeout_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      wait_q      <= wait_d;
      w_flat_q    <= w_flat_d;
      a_flat_q    <= a_flat_d;
      eng_start_q <= eng_start_d;
      m_valid_q   <= m_valid_d;
      m_result_q  <= m_result_d;
      m_timeout_q <= m_timeout_d;
      op_count_q  <= op_count_d;
    end
  end

  assign s_ready          = rst && (state_q == FILL);
  assign busy             = rst && (state_q != FILL);
  assign eng_start        = eng_start_q;
  assign eng_weights_flat = w_flat_q;
  assign eng_acts_flat    = a_flat_q;
  assign m_valid          = m_valid_q;
  assign m_result         = m_result_q;
  assign m_timeout        = m_timeout_q;
  assign op_count         = op_count_q;

endmodule

// File: doc/native_feeder.md
Name: native_feeder

Overview:
- Initiator-side driver for the native dot-product engine.
- Accepts weight/activation operands as a narrow valid/ready beat stream and packs them into the engine's flat N-element operand vectors.
- Issues a one-cycle start to the engine, waits for its done pulse and captures the 16-bit result.
- Returns the result on a valid/ready output stream. It sits between the operand DMA/stream fabric and the engine; one operation is in flight at a time.

Parameters:
- N, 128, elements per dot product; must equal the engine's N.
- WEIGHT_WIDTH, 4, bits per signed weight.
- ACT_WIDTH, 4, bits per signed activation.
- BEAT_LANES, 16, elements per input beat; N % BEAT_LANES == 0.
- TIMEOUT, 32, maximum cycles spent in WAIT before the operation is abandoned; must exceed the engine latency of 10.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
- s_valid  in  1  operand beat valid.
- s_ready  out  1  operand beat ready.
- s_weights  in  BEAT_LANES*WEIGHT_WIDTH  beat weights; lane j at bits [j*WEIGHT_WIDTH +: WEIGHT_WIDTH].
- s_acts  in  BEAT_LANES*ACT_WIDTH  beat activations, same lane layout.
- eng_start  out  1  engine start pulse.
- eng_weights_flat  out  N*WEIGHT_WIDTH  packed weights to the engine.
- eng_acts_flat  out  N*ACT_WIDTH  packed activations to the engine.
- eng_done  in  1  engine done pulse.
- eng_result  in  16  engine result, signed, valid while eng_done=1.
- m_valid  out  1  result valid.
- m_ready  in  1  result ready.
- m_result  out  16  signed dot-product result.
- m_timeout  out  1  qualifies m_valid: the operation timed out and m_result=0.
- op_count  out  16  count of successful results delivered; wraps.
- busy  out  1  high in FIRE, WAIT and HOLD.

Behaviour:
- Reset (rst=0 at an edge) drives every register to its reset value:
  - state=FILL, beat counter 0, wait counter 0.
  - eng_start=0, eng_weights_flat=0, eng_acts_flat=0.
  - m_valid=0, m_result=0, m_timeout=0, op_count=0.
  - s_ready=0 and busy=0 while rst=0.
- States:
  - FILL: s_ready=1.
    - Each beat accepted (s_valid&&s_ready at an edge) writes beat k into elements k*BEAT_LANES .. k*BEAT_LANES+BEAT_LANES-1 of both flat vectors and increments k.
    - Cycles with s_valid=0 do not advance k.
    - Acceptance of beat N/BEAT_LANES-1 sets k=0 and moves to FIRE.
  - FIRE: eng_start=1 for exactly this one cycle; s_ready=0; next state is WAIT with wait counter cleared.
  - WAIT: the wait counter increments every cycle.
    - If eng_done=1 at an edge: m_result<=eng_result, m_timeout<=0, m_valid<=1, go to HOLD.
    - Otherwise, if the counter reaches TIMEOUT-1: m_result<=0, m_timeout<=1, m_valid<=1, go to HOLD.
    - If eng_done=1 on the counter-limit cycle, done wins.
  - HOLD: m_valid, m_result and m_timeout are held stable until m_ready=1 at an edge.
    - On that handshake: m_valid<=0, m_timeout<=0, go to FILL.
    - op_count increments on the handshake only if m_timeout=0.
- Outputs eng_start, the flat vectors and m_* are registered. s_ready and busy decode from the state register only.
- The flat vectors change only on FILL beat acceptance. They are therefore stable from FIRE through the engine's operand capture.
- Nominal timing with an in-spec engine:
  - eng_start is high the cycle after the last beat is accepted.
  - eng_done arrives 10 cycles after eng_start is asserted.
  - m_valid rises the cycle after eng_done.
  - s_ready returns the cycle after the m handshake.
- eng_done outside WAIT is ignored (including stale done after reset or after a timeout).
- m_ready outside HOLD is ignored.
- Result arithmetic is not performed here. m_result is eng_result bit-for-bit as a 16-bit two's-complement value.
- Reset mid-operation, in any state, abandons the operation with no output. The engine is reset by its own reset.

Test Plan:
- All weights=1, acts=1, 8 back-to-back beats, m_ready=1 -> one eng_start pulse the cycle after beat 8; m_valid 11 cycles after eng_start rises; m_result=128; m_timeout=0; op_count=1.
- Weights=-8 (4'h8), acts=7 for all 128 elements -> m_result=16'hE400 (-7168); a second op with weights=7, acts=-1 -> m_result=16'hFC80 (-896); op_count=2.
- Beats separated by random s_valid gaps of 0-5 cycles -> eng_start only after the 8th accepted beat; flat vectors match element order; result is correct.
- Hold m_ready=0 for 5 cycles in HOLD -> m_valid and m_result stable, s_ready=0, extra s_valid beats not accepted; raise m_ready -> s_ready=1 the next cycle.
- Engine model withholds eng_done -> after TIMEOUT=32 cycles in WAIT, m_valid=1, m_timeout=1, m_result=0; op_count unchanged after the handshake; a late eng_done in FILL is ignored.
- Assert rst=0 for one cycle mid-WAIT -> all outputs at reset values the next cycle; the subsequent engine done is ignored; the next full operation produces the correct result and op_count=1.
